// File: rtl/ecp5pll_pkg.sv
// Shared types for the ECP5 PLL dynamic phase-shift sequencer.
//   phase_state_t : sequencer FSM state
//   PHASE_DELAY / PHASE_ADVANCE : values of the phasedir pin
package ecp5pll_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StPulse = 2'd2,
    StGap   = 2'd3
  } phase_state_t;

  localparam logic PHASE_DELAY   = 1'b0;
  localparam logic PHASE_ADVANCE = 1'b1;

endpackage

// File: rtl/phase_pos_tracker.sv
// Four wrapping step-position counters, one per PLL output.
//   clk_i, reset : clock and asynchronous active-high reset
//   step_i       : count one step for output sel_i this cycle
//   sel_i        : output being stepped
//   dir_i        : PHASE_DELAY adds 1, PHASE_ADVANCE subtracts 1
//   pos_o        : output n position at [n*POS_W +: POS_W]
module phase_pos_tracker
  import ecp5pll_pkg::*;
#(
  parameter int unsigned POS_W = 10
) (
  input  logic               clk_i,
  input  logic               reset,
  input  logic               step_i,
  input  logic [1:0]         sel_i,
  input  logic               dir_i,
  output logic [4*POS_W-1:0] pos_o
);

  localparam logic [POS_W-1:0] One = POS_W'(1);

  logic [POS_W-1:0] pos_q [4];
  logic [POS_W-1:0] pos_d [4];

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      pos_d[n] = pos_q[n];
      if (step_i && (sel_i == 2'(n))) begin
        // Natural modulo-2^POS_W wrap in both directions.
        pos_d[n] = (dir_i == PHASE_ADVANCE) ? pos_q[n] - One : pos_q[n] + One;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) pos_q[n] <= '0;
    end else begin
      for (int n = 0; n < 4; n++) pos_q[n] <= pos_d[n];
    end
  end

  for (genvar n = 0; n < 4; n++) begin : g_pos
    assign pos_o[n*POS_W +: POS_W] = pos_q[n];
  end

endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// Sequencer for the ECP5 PLL dynamic phase-shift port.
// Accepts "shift output sel by steps, direction dir" requests and drives
// phasesel/phasedir/phasestep with fixed setup, pulse and gap timing.
//   clk_i, reset            : clock, asynchronous active-high reset
//   req_valid/req_ready     : request handshake
//   req_sel/req_dir/req_steps : request fields
//   busy, done, err         : status; done/err are one-cycle pulses
//   pos_o                   : accumulated step position per output
//   pll_locked              : PLL lock indicator; loss aborts a sequence
//   phasesel/phasedir/phasestep/phaseloadreg : PLL control pins
module ecp5pll_phase_ctrl
  import ecp5pll_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 8,
  parameter int unsigned STEPS_W   = 8,
  parameter int unsigned POS_W     = 10
) (
  input  logic               clk_i,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_sel,
  input  logic               req_dir,
  input  logic [STEPS_W-1:0] req_steps,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [4*POS_W-1:0] pos_o,
  input  logic               pll_locked,
  output logic [1:0]         phasesel,
  output logic               phasedir,
  output logic               phasestep,
  output logic               phaseloadreg
);

  localparam int unsigned MaxSp  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MaxCyc = (MaxSp > GAP_CYC) ? MaxSp : GAP_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0]    CntOne    = CntW'(1);
  localparam logic [CntW-1:0]    SetupLoad = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0]    PulseLoad = CntW'(PULSE_CYC - 1);
  localparam logic [CntW-1:0]    GapLoad   = CntW'(GAP_CYC - 1);
  localparam logic [STEPS_W-1:0] StepOne   = STEPS_W'(1);

  phase_state_t     state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [STEPS_W-1:0] rem_q, rem_d;
  logic [1:0]         sel_q, sel_d;
  logic               dir_q, dir_d;
  logic               upd_q, upd_d;     // latched sel/dir go to the pins next edge
  logic               zero_q, zero_d;   // zero-step request: done pulse pending
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               step_q, step_d;
  logic [1:0]         phasesel_q;
  logic               phasedir_q;
  logic               step_en;
  logic               accept;

  assign req_ready = (state_q == StIdle) && pll_locked;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    upd_d   = 1'b0;
    zero_d  = 1'b0;
    done_d  = zero_q;
    err_d   = 1'b0;
    step_en = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sel_d = req_sel;
          dir_d = req_dir;
          rem_d = req_steps;
          upd_d = 1'b1;
          if (req_steps == '0) begin
            zero_d = 1'b1;
          end else begin
            state_d = StSetup;
            cnt_d   = SetupLoad;
          end
        end
      end
      StSetup: begin
        // The accept cycle itself precedes the pins changing, so the
        // setup count starts one cycle later.
        if (!upd_q) begin
          if (cnt_q == '0) begin
            state_d = StPulse;
            cnt_d   = PulseLoad;
            rem_d   = rem_q - StepOne;
            step_en = 1'b1;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          state_d = StGap;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          if (rem_q != '0) begin
            state_d = StPulse;
            cnt_d   = PulseLoad;
            rem_d   = rem_q - StepOne;
            step_en = 1'b1;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase

    // Lock loss overrides any in-flight transition; counted steps stay counted.
    if ((state_q != StIdle) && !pll_locked) begin
      state_d = StIdle;
      rem_d   = '0;
      step_en = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end

    step_d = (state_d == StPulse);
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      sel_q      <= '0;
      dir_q      <= 1'b0;
      upd_q      <= 1'b0;
      zero_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      step_q     <= 1'b0;
      phasesel_q <= '0;
      phasedir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      upd_q   <= upd_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      err_q   <= err_d;
      step_q  <= step_d;
      if (upd_q) begin
        phasesel_q <= sel_q;
        phasedir_q <= dir_q;
      end
    end
  end

  phase_pos_tracker #(
    .POS_W(POS_W)
  ) u_pos (
    .clk_i  (clk_i),
    .reset  (reset),
    .step_i (step_en),
    .sel_i  (sel_q),
    .dir_i  (dir_q),
    .pos_o  (pos_o)
  );

  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign err          = err_q;
  assign phasesel     = phasesel_q;
  assign phasedir     = phasedir_q;
  assign phasestep    = step_q;
  assign phaseloadreg = 1'b0;

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
module tb_ecp5pll_phase_ctrl;

  localparam int S     = 4;
  localparam int P     = 4;
  localparam int G     = 8;
  localparam int T     = P + G;
  localparam int POS_W = 10;

  logic              clk_i = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_sel;
  logic              req_dir;
  logic [7:0]        req_steps;
  logic              busy, done, err;
  logic [4*POS_W-1:0] pos_o;
  logic              pll_locked;
  logic [1:0]        phasesel;
  logic              phasedir, phasestep, phaseloadreg;

  int checks = 0;
  int errors = 0;
  int exp_pos[4];

  always #5 clk_i = ~clk_i;

  ecp5pll_phase_ctrl #(
    .SETUP_CYC(S), .PULSE_CYC(P), .GAP_CYC(G), .STEPS_W(8), .POS_W(POS_W)
  ) dut (
    .clk_i        (clk_i),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sel      (req_sel),
    .req_dir      (req_dir),
    .req_steps    (req_steps),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .pos_o        (pos_o),
    .pll_locked   (pll_locked),
    .phasesel     (phasesel),
    .phasedir     (phasedir),
    .phasestep    (phasestep),
    .phaseloadreg (phaseloadreg)
  );

  // Reference position model: plain modular arithmetic on integers.
  function automatic void model_move(input int sel, input logic dir, input int k);
    exp_pos[sel] = (((exp_pos[sel] + (dir ? -k : k)) % 1024) + 1024) % 1024;
  endfunction

  function automatic logic [4*POS_W-1:0] model_pos();
    logic [4*POS_W-1:0] v;
    for (int n = 0; n < 4; n++) v[n*POS_W +: POS_W] = POS_W'(exp_pos[n]);
    return v;
  endfunction

  task automatic check_pos(input string name);
    logic [4*POS_W-1:0] e;
    e = model_pos();
    checks++;
    if (pos_o !== e) begin
      errors++;
      $display("FAIL %s: pos_o=%h required %h", name, pos_o, e);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pll_locked = 1'b0; req_valid = 1'b0;
    req_sel = '0; req_dir = 1'b0; req_steps = '0;
    for (int n = 0; n < 4; n++) exp_pos[n] = 0;
    #2;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: req_ready=%b required 0", req_ready);
    end
    checks++;
    if ({busy, done, err, phasestep, phaseloadreg, phasedir, phasesel} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: busy/done/err/step/load/dir/sel=%b required 0",
               {busy, done, err, phasestep, phaseloadreg, phasedir, phasesel});
    end
    check_pos("reset_pos");
    repeat (2) @(negedge clk_i);
    pll_locked = 1'b1;
    reset = 1'b0;
    @(negedge clk_i);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_lock: req_ready=%b required 1", req_ready);
    end
  endtask

  // Single request, observed cycle by cycle relative to the accept edge.
  task automatic run_req(input logic [1:0] sel, input logic dir, input int steps);
    bit ok;
    int exp_done, done_at, ndone, nerr, high, sel_bad, busy_bad;
    int rises[$];
    logic prev;
    bit rise_ok;
    @(negedge clk_i);
    req_sel = sel; req_dir = dir; req_steps = 8'(steps); req_valid = 1'b1;
    wait_ready(ok);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk_i);
    #1 req_valid = 1'b0;
    exp_done = (steps == 0) ? 1 : 1 + S + steps * T;
    done_at = -1; ndone = 0; nerr = 0; high = 0; sel_bad = 0; busy_bad = 0; prev = 1'b0;
    for (int rel = 0; rel <= exp_done + 3; rel++) begin
      @(negedge clk_i);
      if (phasestep && !prev) rises.push_back(rel);
      if (phasestep) high++;
      prev = phasestep;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = rel;
      end
      if (err) nerr++;
      if (rel >= 1 && (phasesel !== sel || phasedir !== dir)) sel_bad++;
      if (busy !== ((steps > 0) && (rel < exp_done))) busy_bad++;
    end
    model_move(int'(sel), dir, steps);

    checks++;
    if (done_at != exp_done) begin
      errors++;
      $display("FAIL done_cycle sel=%0d steps=%0d: done at %0d required %0d",
               sel, steps, done_at, exp_done);
    end
    checks++;
    if (ndone != 1 || nerr != 0) begin
      errors++;
      $display("FAIL pulse_count steps=%0d: done=%0d err=%0d required 1 and 0",
               steps, ndone, nerr);
    end
    rise_ok = (rises.size() == steps);
    for (int k = 0; k < rises.size() && rise_ok; k++)
      if (rises[k] != 1 + S + k * T) rise_ok = 1'b0;
    checks++;
    if (!rise_ok) begin
      errors++;
      $display("FAIL rise_cycles steps=%0d: %0d rises first at %0d, required %0d first at %0d",
               steps, rises.size(), (rises.size() > 0) ? rises[0] : -1, steps, 1 + S);
    end
    checks++;
    if (high != steps * P) begin
      errors++;
      $display("FAIL step_high_cycles: %0d required %0d", high, steps * P);
    end
    checks++;
    if (sel_bad != 0 || busy_bad != 0) begin
      errors++;
      $display("FAIL sel_dir_busy: %0d sel/dir and %0d busy cycles wrong, required 0",
               sel_bad, busy_bad);
    end
    check_pos("pos_after_req");
  endtask

  task automatic test_directed();
    run_req(2'd1, 1'b0, 1);
    run_req(2'd2, 1'b1, 3);
    run_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
  endtask

  task automatic test_lock_loss();
    bit ok;
    logic [1:0] sel;
    logic dir;
    int err_at, ndone, nerr, high;
    logic rdy27, busy27;
    sel = 2'($urandom_range(0, 3));
    dir = 1'($urandom_range(0, 1));
    @(negedge clk_i);
    req_sel = sel; req_dir = dir; req_steps = 8'd5; req_valid = 1'b1;
    wait_ready(ok);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk_i);
    #1 req_valid = 1'b0;
    err_at = -1; ndone = 0; nerr = 0; high = 0; rdy27 = 1'bx; busy27 = 1'bx;
    for (int rel = 0; rel <= 40; rel++) begin
      @(negedge clk_i);
      if (phasestep) high++;
      if (done) ndone++;
      if (err) begin
        nerr++;
        if (err_at < 0) err_at = rel;
      end
      if (rel == 27) begin
        rdy27 = req_ready;
        busy27 = busy;
      end
      // Mid-way through the gap that follows the second step.
      if (rel == 24) pll_locked = 1'b0;
    end
    model_move(int'(sel), dir, 2);
    checks++;
    if (err_at != 25 || nerr != 1 || ndone != 0) begin
      errors++;
      $display("FAIL lock_loss_err: err at %0d (count %0d), done count %0d, required 25/1/0",
               err_at, nerr, ndone);
    end
    checks++;
    if (high != 2 * P) begin
      errors++; $display("FAIL lock_loss_steps: %0d high cycles required %0d", high, 2 * P);
    end
    checks++;
    if (rdy27 !== 1'b0 || busy27 !== 1'b0) begin
      errors++;
      $display("FAIL unlocked_idle: ready=%b busy=%b required 0 0", rdy27, busy27);
    end
    check_pos("lock_loss_pos");
    pll_locked = 1'b1;
    @(negedge clk_i);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL relock_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [1:0] sel_a, sel_b;
    logic dir_a, dir_b;
    int na, nb, hs_at, exp_hs, exp_b;
    int dones[$];
    logic [1:0] ps_hs1, ps_hs2;
    sel_a = 2'($urandom_range(0, 3));
    sel_b = sel_a + 2'd1;
    dir_a = 1'($urandom_range(0, 1));
    dir_b = 1'($urandom_range(0, 1));
    na = int'($urandom_range(1, 2));
    nb = int'($urandom_range(1, 2));
    exp_hs = 1 + S + na * T;
    exp_b = exp_hs + 1 + 1 + S + nb * T;
    ps_hs1 = 2'bxx; ps_hs2 = 2'bxx;
    @(negedge clk_i);
    req_sel = sel_a; req_dir = dir_a; req_steps = 8'(na); req_valid = 1'b1;
    wait_ready(ok);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk_i);
    #1 req_sel = sel_b; req_dir = dir_b; req_steps = 8'(nb);
    hs_at = -1;
    for (int rel = 0; rel <= 70; rel++) begin
      @(negedge clk_i);
      if (done) dones.push_back(rel);
      if (hs_at >= 0 && rel == hs_at + 1) ps_hs1 = phasesel;
      if (hs_at >= 0 && rel == hs_at + 2) ps_hs2 = phasesel;
      if (rel > 0 && hs_at < 0 && req_ready && req_valid) begin
        hs_at = rel;
        @(posedge clk_i);
        #1 req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    model_move(int'(sel_a), dir_a, na);
    model_move(int'(sel_b), dir_b, nb);
    checks++;
    if (hs_at != exp_hs || dones.size() != 2 || dones[0] != exp_hs) begin
      errors++;
      $display("FAIL b2b_accept: accept cycle %0d, %0d dones first at %0d, required %0d",
               hs_at, dones.size(), (dones.size() > 0) ? dones[0] : -1, exp_hs);
    end
    checks++;
    if (dones.size() != 2 || dones[dones.size() - 1] != exp_b) begin
      errors++;
      $display("FAIL b2b_second_done: at %0d required %0d",
               (dones.size() > 0) ? dones[dones.size() - 1] : -1, exp_b);
    end
    checks++;
    if (ps_hs1 !== sel_a || ps_hs2 !== sel_b) begin
      errors++;
      $display("FAIL b2b_phasesel: %0d then %0d required %0d then %0d",
               ps_hs1, ps_hs2, sel_a, sel_b);
    end
    check_pos("b2b_pos");
  endtask

  task automatic test_reset_mid_pulse();
    bit ok;
    int nde;
    logic step6;
    @(negedge clk_i);
    req_sel = 2'($urandom_range(0, 3)); req_dir = 1'($urandom_range(0, 1));
    req_steps = 8'd3; req_valid = 1'b1;
    wait_ready(ok);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk_i);
    #1 req_valid = 1'b0;
    for (int rel = 0; rel <= 6; rel++) @(negedge clk_i);
    step6 = phasestep;
    reset = 1'b1;
    #1;
    for (int n = 0; n < 4; n++) exp_pos[n] = 0;
    checks++;
    if (step6 !== 1'b1 || phasestep !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_step: before=%b after=%b required 1 then 0", step6, phasestep);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_status: busy=%b done=%b err=%b required 0", busy, done, err);
    end
    check_pos("reset_mid_pos");
    @(negedge clk_i);
    reset = 1'b0;
    nde = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (done || err || busy || phasestep) nde++;
    end
    checks++;
    if (nde != 0) begin
      errors++;
      $display("FAIL reset_quiet: %0d active cycles after reset, required 0", nde);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_lock_loss();
    test_back_to_back();
    test_random();
    test_reset_mid_pulse();
    run_req(2'd3, 1'b0, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
